reg_file_write_port: RTL and testbench
======================================

Name: reg_file_write_port

Overview:
- Write side of the LC-3 register file: accepts destination-register writes from the writeback stage over a valid/ready handshake.
- Queues writes in a 2-entry in-order FIFO and commits one write per cycle into eight 16-bit registers.
- r0..r7 feed the existing 8:1 16-bit read muxes directly.
- Exposes per-register pending flags for hazard/interlock logic.

Parameters:
- DATA_W, 16, register and write-data width
- ADDR_W, 3, destination register index width
- NUM_REGS, 8, number of registers (2**ADDR_W)
- FIFO_DEPTH, 2, write-queue entries (fixed at 2; other values are not supported)

Ports:
- clk  input  1  single system clock, all state on rising edge
- reset  input  1  synchronous, active-high; sampled on rising edge of clk
- wr_valid  input  1  write request present
- wr_ready  output  1  queue can accept a request this cycle
- wr_addr  input  3  destination register (DR) index
- wr_data  input  16  value to write
- stall  input  1  freeze commits (pipeline hold); queue still accepts while not full
- r0..r7  output  16 each  current register contents, registered
- pending  output  8  bit i = 1 while any queued, uncommitted write targets Ri
- commit_valid  output  1  one-cycle pulse: a write committed on the last edge
- commit_addr  output  3  index committed on the last edge; valid only with commit_valid
- busy  output  1  queue non-empty

Behaviour:
- Reset (synchronous, active-high):
  - r0..r7 = 16'h0000.
  - Queue cleared: count = 0, pointers = 0.
  - commit_valid = 0, commit_addr = 3'b000.
  - pending = 8'h00, busy = 0.
  - wr_ready = 0 while reset is high; 1 on the first cycle after reset deasserts.
- Handshake:
  - Transfer occurs on an edge where wr_valid && wr_ready.
  - wr_ready = !reset && (count < 2). It does not look ahead at same-cycle commits.
  - wr_addr and wr_data are sampled only on transfer. When wr_valid = 0 they are don't-care.
- Queue:
  - Circular, 2 entries, 1-bit read and write pointers, 2-bit count (0..2).
  - Push when a transfer occurs. Pop when count > 0 && !stall.
  - Push and pop on the same edge leave count unchanged. Both pointers advance and wrap 1 -> 0.
- Commit:
  - Each edge with count > 0 && !stall writes the head entry: R[head.addr] <= head.data.
  - The destination is selected through a one-hot 3:8 decode.
  - On that edge: commit_valid <= 1 and commit_addr <= head.addr. Otherwise commit_valid <= 0.
- Latency:
  - A request transferred on edge N is at the head on edge N+1 if the queue was empty, and commits on that edge when stall = 0.
  - The new value is visible on rX during the cycle after edge N+1.
- Throughput: 1 write/cycle sustained when stall = 0. Count never exceeds 1 in that case.
- Stall: holds the queue. The first request fills one entry, the second fills the other, then wr_ready = 0. Register contents do not change.
- Pending:
  - Combinational OR over valid queue entries of onehot(entry.addr).
  - Clears on the edge that commits the last queued write to that register.
- Ordering:
  - Strictly FIFO.
  - Two queued writes to the same register commit on successive edges; the later write wins.
  - The pending bit stays set until both have committed.
- Reset mid-operation: all queued writes are discarded, never committed. Registers are cleared even if a commit was due on the same edge, since reset has priority.
- No read-during-write bypass: rX shows the old value in the commit cycle. Forwarding belongs to the consumer.
- Width rules:
  - Data is stored unmodified: no sign extension, no truncation.
  - wr_addr is used in full; all 8 codes are legal.

Decomposition:
- Shared package / header: DATA_W = 16, ADDR_W = 3, NUM_REGS = 8, RESET_VAL = 16'h0000.
- The queue entry layout {addr[2:0], data[15:0]} lives in the same header for reuse by the writeback stage.
- Sub-module: decoder_3_8, a combinational one-hot destination decoder and the natural counterpart to the read-side mux. Instantiated once for the commit write enables.
- Pending is computed inline, with one onehot per entry.

Test Plan:
- Reset: hold reset for 2 cycles with wr_valid = 1 -> wr_ready = 0, no transfer, r0..r7 = 0x0000, pending = 0x00, commit_valid = 0. First cycle after reset: wr_ready = 1.
- Single write: transfer R3 = 0x1234 on edge N -> pending = 8'h08 in the following cycle; commit on edge N+1 with commit_valid = 1, commit_addr = 3; r3 = 0x1234 after N+1; pending = 0x00; other registers unchanged.
- Back-to-back, stall = 0: transfer R0 = 0xAAAA, R7 = 0x5555, R1 = 0xFFFF on consecutive edges -> wr_ready stays 1; commits occur on consecutive edges in that order; busy drops one edge after the last transfer.
- Stall fill: with stall = 1, transfer R2 = 0x0001 and R4 = 0x0002 -> wr_ready = 0, pending = 8'h14, r2 = r4 = 0. Release stall -> commits follow in order and wr_ready returns to 1 the cycle after the first commit.
- Same-address ordering: with stall = 1, queue R5 = 0x1111 then R5 = 0x2222; release -> r5 goes 0x1111 then 0x2222; pending[5] clears only after the second commit.
- Reset mid-operation: with a stalled, full queue and r6 = 0xBEEF, assert reset for 1 cycle -> queue empty, r6 = 0x0000, no commit_valid pulse for the dropped entries.

Source files
------------

// File: rtl/reg_file_write_port_pkg.sv
// Shared widths, reset value and write-queue entry layout for the LC-3 register file.
// The writeback stage reuses wr_entry_t when it builds a request.
package reg_file_write_port_pkg;
  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 8;
  localparam logic [DATA_W-1:0] RESET_VAL = 16'h0000;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_entry_t;
endpackage

// File: rtl/reg_file_write_port_decoder_3_8.sv
// One-hot destination decoder; the write-side counterpart of the 8:1 read mux.
module decoder_3_8 #(
  parameter int ADDR_W   = reg_file_write_port_pkg::ADDR_W,
  parameter int NUM_REGS = reg_file_write_port_pkg::NUM_REGS
) (
  input  logic [ADDR_W-1:0]   addr,
  input  logic                en,
  output logic [NUM_REGS-1:0] onehot
);
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_dec
      assign onehot[gi] = en && (addr == ADDR_W'(gi));
    end
  endgenerate
endmodule

// File: rtl/reg_file_write_port.sv
// LC-3 register-file write port: 2-entry in-order write queue, one commit per
// cycle into r0..r7, with per-register pending flags for interlock logic.
module reg_file_write_port #(
  parameter int DATA_W     = reg_file_write_port_pkg::DATA_W,
  parameter int ADDR_W     = reg_file_write_port_pkg::ADDR_W,
  parameter int NUM_REGS   = reg_file_write_port_pkg::NUM_REGS,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                stall,
  output logic [DATA_W-1:0]   r0,
  output logic [DATA_W-1:0]   r1,
  output logic [DATA_W-1:0]   r2,
  output logic [DATA_W-1:0]   r3,
  output logic [DATA_W-1:0]   r4,
  output logic [DATA_W-1:0]   r5,
  output logic [DATA_W-1:0]   r6,
  output logic [DATA_W-1:0]   r7,
  output logic [NUM_REGS-1:0] pending,
  output logic                commit_valid,
  output logic [ADDR_W-1:0]   commit_addr,
  output logic                busy
);
  import reg_file_write_port_pkg::*;

  localparam logic [1:0] DEPTH = 2'(FIFO_DEPTH);

  wr_entry_t           fifo_reg [2];
  logic                rd_ptr_reg;
  logic                wr_ptr_reg;
  logic [1:0]          count_reg;
  logic [DATA_W-1:0]   regs_reg [NUM_REGS];
  logic                commit_valid_reg;
  logic [ADDR_W-1:0]   commit_addr_reg;

  wr_entry_t           head;
  logic                push;
  logic                pop;
  logic [NUM_REGS-1:0] we;
  logic                entry_valid [2];
  logic [NUM_REGS-1:0] entry_oh    [2];

  // Readiness is based on the current count only, never on a same-cycle commit.
  assign wr_ready = !reset && (count_reg < DEPTH);
  assign push     = wr_valid && wr_ready;
  assign pop      = (count_reg != 2'd0) && !stall;
  assign head     = fifo_reg[rd_ptr_reg];

  decoder_3_8 #(
    .ADDR_W  (ADDR_W),
    .NUM_REGS(NUM_REGS)
  ) u_dec (
    .addr  (head.addr),
    .en    (pop),
    .onehot(we)
  );

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_reg[wr_ptr_reg] <= '{addr: wr_addr, data: wr_data};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_reg       <= 1'b0;
      wr_ptr_reg       <= 1'b0;
      count_reg        <= 2'd0;
      commit_valid_reg <= 1'b0;
      commit_addr_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
      commit_valid_reg <= pop;
      if (pop) commit_addr_reg <= head.addr;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_regs
      always_ff @(posedge clk) begin
        if (reset) begin
          regs_reg[gi] <= RESET_VAL;
        end else if (we[gi]) begin
          regs_reg[gi] <= head.data;
        end
      end
    end

    // An entry is live if the queue is full, or it is the single entry at the head.
    for (gi = 0; gi < 2; gi++) begin : g_pend
      assign entry_valid[gi] = (count_reg == 2'd2) ||
                               ((count_reg == 2'd1) && (rd_ptr_reg == 1'(gi)));
      assign entry_oh[gi]    = entry_valid[gi] ? (NUM_REGS'(1) << fifo_reg[gi].addr) : '0;
    end
  endgenerate

  assign pending      = entry_oh[0] | entry_oh[1];
  assign busy         = (count_reg != 2'd0);
  assign commit_valid = commit_valid_reg;
  assign commit_addr  = commit_addr_reg;

  assign r0 = regs_reg[0];
  assign r1 = regs_reg[1];
  assign r2 = regs_reg[2];
  assign r3 = regs_reg[3];
  assign r4 = regs_reg[4];
  assign r5 = regs_reg[5];
  assign r6 = regs_reg[6];
  assign r7 = regs_reg[7];
endmodule

// File: tb/tb_reg_file_write_port.sv
// Scoreboard bench: the driver queues accepted writes; a negedge monitor pops on
// each commit pulse and checks registers, pending, busy and wr_ready against a model.
module tb_reg_file_write_port;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [2:0]  wr_addr = 3'd0;
  logic [15:0] wr_data = 16'h0;
  logic        stall = 1'b0;
  logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7;
  logic [7:0]  pending;
  logic        commit_valid;
  logic [2:0]  commit_addr;
  logic        busy;

  typedef struct {
    logic [2:0]  a;
    logic [15:0] d;
  } req_t;

  req_t        q[$];
  logic [15:0] model_regs [8];
  logic [15:0] rv [8];
  bit          started = 0;
  bit          exp_commit = 0;
  bit          exp_reset = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  reg_file_write_port dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .stall(stall),
    .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5), .r6(r6), .r7(r7),
    .pending(pending), .commit_valid(commit_valid), .commit_addr(commit_addr),
    .busy(busy)
  );

  assign rv[0] = r0; assign rv[1] = r1; assign rv[2] = r2; assign rv[3] = r3;
  assign rv[4] = r4; assign rv[5] = r5; assign rv[6] = r6; assign rv[7] = r7;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One driven cycle; the model decides acceptance from its own queue occupancy.
  task automatic step(input logic v, input logic [2:0] a, input logic [15:0] d,
                      input logic s, input logic r);
    @(negedge clk);
    #2;
    wr_valid = v; wr_addr = a; wr_data = d; stall = s; reset = r;
    #1;
    if (r) begin
      exp_reset  = 1;
      exp_commit = 0;
      q.delete();
      started    = 1;
    end else begin
      exp_reset  = 0;
      exp_commit = (q.size() > 0) && !s;
      if (v && q.size() < 2) begin
        q.push_back('{a: a, d: d});
        $display("push R%0d <= 0x%04h (stall=%0b, queued=%0d)", a, d, s, q.size());
      end
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      logic [7:0] exp_pend;
      req_t e;
      if (exp_reset) begin
        for (int i = 0; i < 8; i++) model_regs[i] = 16'h0000;
        check("commit_valid_in_reset", {31'd0, commit_valid}, 32'd0);
        check("commit_addr_in_reset", {29'd0, commit_addr}, 32'd0);
      end else begin
        check("commit_valid", {31'd0, commit_valid}, {31'd0, exp_commit});
        if (commit_valid) begin
          if (q.size() == 0) begin
            check("commit_with_empty_queue", 32'd1, 32'd0);
          end else begin
            e = q.pop_front();
            check("commit_addr", {29'd0, commit_addr}, {29'd0, e.a});
            model_regs[e.a] = e.d;
            $display("commit R%0d = 0x%04h", e.a, e.d);
          end
        end
      end
      for (int i = 0; i < 8; i++)
        check($sformatf("r%0d", i), {16'd0, rv[i]}, {16'd0, model_regs[i]});
      exp_pend = 8'h00;
      foreach (q[k]) exp_pend[q[k].a] = 1'b1;
      check("pending", {24'd0, pending}, {24'd0, exp_pend});
      check("busy", {31'd0, busy}, {31'd0, q.size() > 0});
      check("wr_ready", {31'd0, wr_ready}, {31'd0, !reset && (q.size() < 2)});
    end
  end

  initial begin
    // Reset held two cycles with a request present
    step(1, 3'd2, 16'hDEAD, 0, 1);
    step(1, 3'd2, 16'hDEAD, 0, 1);
    step(0, 3'd0, 16'h0000, 0, 0);
    // Single write
    step(1, 3'd3, 16'h1234, 0, 0);
    step(0, 3'd0, 16'h0000, 0, 0);
    step(0, 3'd0, 16'h0000, 0, 0);
    // Back-to-back
    step(1, 3'd0, 16'hAAAA, 0, 0);
    step(1, 3'd7, 16'h5555, 0, 0);
    step(1, 3'd1, 16'hFFFF, 0, 0);
    repeat (3) step(0, 3'd0, 16'h0000, 0, 0);
    // Stall fill, then an attempt while full
    step(1, 3'd2, 16'h0001, 1, 0);
    step(1, 3'd4, 16'h0002, 1, 0);
    step(1, 3'd6, 16'h9999, 1, 0);
    repeat (3) step(0, 3'd0, 16'h0000, 0, 0);
    // Same-address ordering
    step(1, 3'd5, 16'h1111, 1, 0);
    step(1, 3'd5, 16'h2222, 1, 0);
    step(0, 3'd0, 16'h0000, 1, 0);
    repeat (3) step(0, 3'd0, 16'h0000, 0, 0);
    // Reset with a full stalled queue and r6 loaded
    step(1, 3'd6, 16'hBEEF, 0, 0);
    step(0, 3'd0, 16'h0000, 0, 0);
    step(1, 3'd1, 16'h0101, 1, 0);
    step(1, 3'd2, 16'h0202, 1, 0);
    step(0, 3'd0, 16'h0000, 0, 1);
    repeat (3) step(0, 3'd0, 16'h0000, 0, 0);
    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
           16'($urandom), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 199) == 0));
    end
    repeat (4) step(0, 3'd0, 16'h0000, 0, 0);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
